// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults and reset polarity for the multi-port register file
package regfile_mp_pkg;
  localparam logic RST_ENABLE = 1'b0;
  localparam int   REG_BUS_W  = 32;
  localparam int   REG_NUM    = 32;
  localparam int   REG_ADDR_W = $clog2(REG_NUM);
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits (issue sets, write-back clears, flush clears all)
//   clk, rst_n        : clock, synchronous active-low reset
//   rs_addr_i/valid   : read ports looked up against the busy bits
//   rd_addr_i, wr_en_i: write-back ports (wr_en_i already masked by reset)
//   iss_addr_i/valid  : destination reservation from id
//   flush_i           : clears every busy bit
//   rs_busy_o         : per read port, source still has an outstanding producer
module regfile_scoreboard import regfile_mp_pkg::*; #(
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr_i,
  input  logic [NUM_RD-1:0]        rs_req_rd_valid_i,
  input  logic [NUM_WR*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     iss_valid_i,
  input  logic                     flush_i,
  output logic [NUM_RD-1:0]        rs_busy_o
);
  logic [NUM_REGS-1:0] r_busy, w_busy_nxt, w_wr_hit;
  always_comb begin
    w_wr_hit = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en_i[j]) w_wr_hit[rd_addr_i[j*ADDR_W +: ADDR_W]] = 1'b1;
    w_busy_nxt = r_busy & ~w_wr_hit;
    // issue applied after the clear so a same-cycle issue wins over write-back
    if (iss_valid_i) w_busy_nxt[iss_addr_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    if (flush_i) w_busy_nxt = '0;
  end
  always_ff @(posedge clk)
    r_busy <= (rst_n == RST_ENABLE) ? '0 : w_busy_nxt;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    assign w_a = rs_addr_i[k*ADDR_W +: ADDR_W];
    assign rs_busy_o[k] = r_busy[w_a] & rs_req_rd_valid_i[k] & ~((BYPASS != 0) & w_wr_hit[w_a]);
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with x0 hardwired, write bypass and busy scoreboard
//   clk, rst_n                         : clock, synchronous active-low reset
//   rs_addr_i, rs_req_rd_valid_i       : read ports (combinational, zero latency)
//   rs_reg_data_o, rs_busy_o           : read data and scoreboard hit per read port
//   rd_addr_i, rd_data_i, rd_req_wr_valid_i : write ports, highest index wins on conflict
//   iss_addr_i, iss_valid_i, flush_i   : busy reservation and pipeline flush
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int DATA_W   = REG_BUS_W,
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr_i,
  input  logic [NUM_RD-1:0]        rs_req_rd_valid_i,
  output logic [NUM_RD*DATA_W-1:0] rs_reg_data_o,
  output logic [NUM_RD-1:0]        rs_busy_o,
  input  logic [NUM_WR*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] rd_data_i,
  input  logic [NUM_WR-1:0]        rd_req_wr_valid_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     iss_valid_i,
  input  logic                     flush_i
);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_WR-1:0] w_wr_en;
  // writes in a reset cycle are discarded, so they must not be forwarded either
  assign w_wr_en = rd_req_wr_valid_i & {NUM_WR{rst_n != RST_ENABLE}};
  always_ff @(posedge clk)
    if (rst_n == RST_ENABLE) r_regs <= '{default: '0};
    else
      for (int j = 0; j < NUM_WR; j++)
        if (w_wr_en[j] && rd_addr_i[j*ADDR_W +: ADDR_W] != '0)
          r_regs[rd_addr_i[j*ADDR_W +: ADDR_W]] <= rd_data_i[j*DATA_W +: DATA_W];
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    assign w_a = rs_addr_i[k*ADDR_W +: ADDR_W];
    always_comb begin
      w_d = r_regs[w_a];
      for (int j = 0; j < NUM_WR; j++)
        if (BYPASS != 0 && w_wr_en[j] && rd_addr_i[j*ADDR_W +: ADDR_W] == w_a)
          w_d = rd_data_i[j*DATA_W +: DATA_W];
    end
    assign rs_reg_data_o[k*DATA_W +: DATA_W] = (rs_req_rd_valid_i[k] && w_a != '0) ? w_d : '0;
  end
  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(BYPASS)
  ) u_sb (
    .clk               (clk),
    .rst_n             (rst_n),
    .rs_addr_i         (rs_addr_i),
    .rs_req_rd_valid_i (rs_req_rd_valid_i),
    .rd_addr_i         (rd_addr_i),
    .wr_en_i           (w_wr_en),
    .iss_addr_i        (iss_addr_i),
    .iss_valid_i       (iss_valid_i),
    .flush_i           (flush_i),
    .rs_busy_o         (rs_busy_o)
  );
endmodule
